half_adder_v1: RTL and testbench

// - Bit-wise half adder. It exposes combinational sum/carry per lane, plus a

---
 rtl/half_adder_v1_pkg.sv | 19 +
 rtl/half_adder_v1_ha_cell.sv | 19 +
 rtl/half_adder_v1.sv | 50 +++++
 tb/tb_half_adder_v1.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/half_adder_v1_pkg.sv
// rtl/half_adder_v1_pkg.sv - shared defaults and types for the half adder block
package half_adder_v1_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_bit_t;

    function automatic ha_bit_t ha_eval(input logic a, input logic b);
        ha_bit_t r;
        r.sum   = a ^ b;
        r.carry = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_v1_ha_cell.sv
// rtl/half_adder_v1_ha_cell.sv - single-bit combinational half adder cell
module ha_cell
    import half_adder_v1_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_bit_t res;

    always_comb begin
        res   = ha_eval(a, b);
        sum   = res.sum;
        carry = res.carry;
    end

endmodule

// File: rtl/half_adder_v1.sv
// rtl/half_adder_v1.sv - WIDTH-lane half adder with registered result and carry counter
module half_adder_v1
    import half_adder_v1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum[i]),
            .carry (carry[i])
        );
    end

    // a/b are only looked at when in_valid is high, so X on idle cycles never reaches state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q     <= '0;
            carry_q   <= '0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else if (in_valid) begin
            sum_q     <= sum;
            carry_q   <= carry;
            out_valid <= 1'b1;
            if (|carry && carry_cnt != CNT_MAX)
                carry_cnt <= carry_cnt + 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_half_adder_v1.sv
// tb/tb_half_adder_v1.sv - directed self-checking bench for half_adder_v1
module tb_half_adder_v1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=1 instance
    logic       rst1, v1;
    logic [0:0] a1, b1, s1, c1, sq1, cq1;
    logic       ov1;
    logic [15:0] cnt1;

    // WIDTH=4 instance
    logic       rst4, v4;
    logic [3:0] a4, b4, s4, c4, sq4, cq4;
    logic       ov4;
    logic [15:0] cnt4;

    // CNT_W=2 instance
    logic       rsts, vs;
    logic [0:0] as_, bs, ss, cs, sqs, cqs;
    logic       ovs;
    logic [1:0] cnts;

    half_adder_v1 #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst1), .a(a1), .b(b1), .in_valid(v1),
        .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1),
        .out_valid(ov1), .carry_cnt(cnt1)
    );

    half_adder_v1 #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst4), .a(a4), .b(b4), .in_valid(v4),
        .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4),
        .out_valid(ov4), .carry_cnt(cnt4)
    );

    half_adder_v1 #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rsts), .a(as_), .b(bs), .in_valid(vs),
        .sum(ss), .carry(cs), .sum_q(sqs), .carry_q(cqs),
        .out_valid(ovs), .carry_cnt(cnts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] tt_exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};  // {sum,carry}
    logic [3:0] va [2] = '{4'hF, 4'h3};
    logic [3:0] vb [2] = '{4'h5, 4'hC};
    logic [3:0] es [2] = '{4'hA, 4'hF};
    logic [3:0] ec [2] = '{4'h5, 4'h0};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst1 = 0; v1 = 0; a1 = 0; b1 = 0;
        rst4 = 0; v4 = 0; a4 = 0; b4 = 0;
        rsts = 0; vs = 0; as_ = 0; bs = 0;

        // combinational truth table, held in reset to show it is clock independent
        for (int i = 0; i < 4; i++) begin
            a1 = tt_ab[i][1];
            b1 = tt_ab[i][0];
            #19;
            check($sformatf("tt_sum_%0d", i),   {31'd0, s1}, {31'd0, tt_exp[i][1]});
            check($sformatf("tt_carry_%0d", i), {31'd0, c1}, {31'd0, tt_exp[i][0]});
            #1;
        end

        // reset wins over in_valid
        v1 = 1; a1 = 1; b1 = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_comb_carry", {31'd0, c1}, 32'd1);
        end
        check("rst_sum_q",   {31'd0, sq1}, 32'd0);
        check("rst_carry_q", {31'd0, cq1}, 32'd0);
        check("rst_valid",   {31'd0, ov1}, 32'd0);
        check("rst_cnt",     {16'd0, cnt1}, 32'd0);

        // one-cycle latency
        rst1 = 1;
        tick();
        v1 = 0;
        check("lat_sum_q",   {31'd0, sq1}, 32'd0);
        check("lat_carry_q", {31'd0, cq1}, 32'd1);
        check("lat_valid",   {31'd0, ov1}, 32'd1);
        a1 = 'x; b1 = 'x;
        tick();
        check("idle_valid",   {31'd0, ov1}, 32'd0);
        check("idle_sum_q",   {31'd0, sq1}, 32'd0);
        check("idle_carry_q", {31'd0, cq1}, 32'd1);
        check("idle_cnt",     {16'd0, cnt1}, 32'd1);
        tick();
        check("xin_carry_q", {31'd0, cq1}, 32'd1);
        check("xin_cnt",     {16'd0, cnt1}, 32'd1);

        // mid-stream reset discards the accepted vector
        v1 = 1; a1 = 1; b1 = 0;
        tick();
        check("mid_pre_valid", {31'd0, ov1}, 32'd1);
        check("mid_pre_sum_q", {31'd0, sq1}, 32'd1);
        check("mid_pre_cnt",   {16'd0, cnt1}, 32'd1);
        rst1 = 0;
        tick();
        check("mid_valid", {31'd0, ov1}, 32'd0);
        check("mid_cnt",   {16'd0, cnt1}, 32'd0);
        v1 = 0;

        // WIDTH=4 back-to-back stream
        tick();
        rst4 = 1;
        for (int i = 0; i < 2; i++) begin
            v4 = 1; a4 = va[i]; b4 = vb[i];
            #1;
            check($sformatf("w4_comb_sum_%0d", i),   {28'd0, s4}, {28'd0, es[i]});
            check($sformatf("w4_comb_carry_%0d", i), {28'd0, c4}, {28'd0, ec[i]});
            tick();
            check($sformatf("w4_sum_q_%0d", i),   {28'd0, sq4}, {28'd0, es[i]});
            check($sformatf("w4_carry_q_%0d", i), {28'd0, cq4}, {28'd0, ec[i]});
            check($sformatf("w4_valid_%0d", i),   {31'd0, ov4}, 32'd1);
        end
        v4 = 0;
        check("w4_cnt", {16'd0, cnt4}, 32'd1);
        tick();
        check("w4_valid_end", {31'd0, ov4}, 32'd0);
        check("w4_cnt_end",   {16'd0, cnt4}, 32'd1);

        // CNT_W=2 saturation
        tick();
        rsts = 1;
        vs = 1; as_ = 1; bs = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_cnt_%0d", i), {30'd0, cnts}, {30'd0, sat_exp[i]});
        end
        vs = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
